// File: rtl/alu_result_buffer_pkg.sv
// alu_pkg: shared ALU command encodings and flag bit positions for the result buffer
package alu_pkg;
  typedef enum logic [2:0] {
    ADD  = 3'd0,
    SUB  = 3'd1,
    XOR  = 3'd2,
    SLT  = 3'd3,
    AND  = 3'd4,
    NAND = 3'd5,
    NOR  = 3'd6,
    OR   = 3'd7
  } alu_cmd_e;
  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 3;
  localparam int FLAG_W = 4;
  function automatic logic is_arith(input logic [2:0] cmd);
    return cmd == ADD || cmd == SUB;
  endfunction
endpackage

// File: rtl/alu_result_buffer_if.sv
// alu_result_buffer_if: ALU-side capture and consumer-side valid/ready bundle
interface alu_result_buffer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] result;
  logic        carryout;
  logic        zero;
  logic        overflow;
  logic [2:0]  command;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_flags;
  logic [2:0]  out_command;
  modport master (
    output in_valid, result, carryout, zero, overflow, command, out_ready,
    input  in_ready, out_valid, out_result, out_flags, out_command
  );
  modport slave (
    input  in_valid, result, carryout, zero, overflow, command, out_ready,
    output in_ready, out_valid, out_result, out_flags, out_command
  );
endinterface

// File: rtl/alu_result_buffer_fifo.sv
// alu_result_fifo: width-parameterised first-word-fall-through FIFO with registered count
module alu_result_fifo #(
  parameter int W     = 39,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push_valid,
  output logic         push_ready,
  input  logic [W-1:0] push_data,
  output logic         pop_valid,
  input  logic         pop_ready,
  output logic [W-1:0] pop_data
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          push, pop;
  assign push_ready = count != (AW+1)'(DEPTH);
  assign pop_valid  = count != '0;
  assign push       = push_valid && push_ready;
  assign pop        = pop_valid && pop_ready;
  assign pop_data   = pop_valid ? mem[rptr] : '0;
  // pointer and occupancy tracking; power-of-two depth lets pointers wrap on their own
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= push ? wptr + AW'(1) : wptr;
      rptr  <= pop ? rptr + AW'(1) : rptr;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  // storage needs no reset: the head is masked to zero while empty
  always_ff @(posedge clk)
    if (push) mem[wptr] <= push_data;
endmodule

// File: rtl/alu_result_buffer.sv
// alu_result_buffer: buffers ALU results with flags and keeps overflow statistics (ALU_ZERO_RECOMPUTE_EN derives zero from result)
module alu_result_buffer
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  alu_result_buffer_if.slave bus,
  input  logic               clear_stats,
  output logic               sticky_overflow,
  output logic [CNT_W-1:0]   overflow_count
);
  localparam int W = 3 + FLAG_W + 32;
  logic [FLAG_W-1:0] flags;
  logic [W-1:0]      head;
  logic              zf, counted;
`ifdef ALU_ZERO_RECOMPUTE_EN
  assign zf = bus.result == 32'd0;
`else
  assign zf = bus.zero;
`endif
  // flag word as stored with each entry
  always_comb begin
    flags         = '0;
    flags[FLAG_C] = bus.carryout;
    flags[FLAG_Z] = zf;
    flags[FLAG_V] = bus.overflow;
    flags[FLAG_N] = bus.result[31];
  end
  alu_result_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push_valid(bus.in_valid),
    .push_ready(bus.in_ready),
    .push_data ({bus.command, flags, bus.result}),
    .pop_valid (bus.out_valid),
    .pop_ready (bus.out_ready),
    .pop_data  (head)
  );
  assign {bus.out_command, bus.out_flags, bus.out_result} = head;
  assign counted = bus.in_valid && bus.in_ready && bus.overflow && is_arith(bus.command);
  // overflow statistics; clear takes priority over a same-cycle counted overflow
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sticky_overflow <= 1'b0;
      overflow_count  <= '0;
    end else if (clear_stats) begin
      sticky_overflow <= 1'b0;
      overflow_count  <= '0;
    end else if (counted) begin
      sticky_overflow <= 1'b1;
      overflow_count  <= &overflow_count ? overflow_count : overflow_count + CNT_W'(1);
    end
endmodule

// File: doc/alu_result_buffer.md
Name: alu_result_buffer

Overview:
- Downstream stage of the 32-bit ALU; captures each ALU result plus flags (carryout, zero, overflow) and the originating command into a small first-word-fall-through FIFO.
- Presents entries to the consumer (register-file writeback or test checker) over a valid/ready handshake.
- Keeps overflow statistics: a sticky flag and a saturating count, for the test driver to read at end of test.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_W, 8, width of the saturating overflow counter.

Ports:
- clk  input  1  single clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  ALU output is valid this cycle.
- in_ready  output  1  buffer can accept an entry.
- result  input  32  ALU result.
- carryout  input  1  ALU carry out.
- zero  input  1  ALU zero flag.
- overflow  input  1  ALU signed overflow.
- command  input  3  ALU command that produced the result.
- out_valid  output  1  head entry valid.
- out_ready  input  1  consumer accepts the head entry.
- out_result  output  32  head result.
- out_flags  output  4  {negative, overflow, zero, carryout} of the head entry.
- out_command  output  3  head command.
- clear_stats  input  1  synchronous clear of the statistics.
- sticky_overflow  output  1  set by any counted overflow since reset or clear.
- overflow_count  output  CNT_W  saturating count of counted overflows.

Behaviour:
- Reset values (reset_n low, asynchronous):
  - count, write pointer and read pointer all 0.
  - out_valid 0; in_ready 1.
  - out_result, out_flags, out_command all 0.
  - sticky_overflow 0; overflow_count 0.
- Reset mid-operation discards all entries immediately.
- Push occurs when in_valid && in_ready at a rising edge.
- Pop occurs when out_valid && out_ready at a rising edge.
- in_ready = (count != DEPTH), derived from registered count only; no dependence on out_ready.
  - When full, a same-cycle pop does not enable a push.
- out_valid = (count != 0).
- out_* are driven from the head entry (FWFT) and hold stable while out_valid && !out_ready.
- Latency: an entry pushed at edge N is visible on out_* after edge N. There is no combinational bypass, so an empty buffer never presents in-cycle data.
- Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both pointers advance.
- Pointers are log2(DEPTH) bits and wrap naturally.
- negative flag = result[31], captured at push.
- Overflow is counted when a push occurs with overflow==1 and command is ADD or SUB. Overflow on any other command is stored in out_flags but not counted.
  - On a counted overflow, sticky_overflow is set to 1.
  - On a counted overflow, overflow_count increments and saturates at 2^CNT_W-1.
- clear_stats in the same cycle as a counted overflow: clear wins; count becomes 0 and sticky becomes 0.
- in_valid while full is ignored; no entry is stored and no stats change. The producer must hold its data.

Optional Feature:
- ALU_ZERO_RECOMPUTE_EN defined: the stored zero flag is (result == 32'd0); the zero input is ignored.
- Undefined: the zero input is stored as given.

Decomposition:
- alu_pkg:
  - Command constants: ADD=0, SUB=1, XOR=2, SLT=3, AND=4, NAND=5, NOR=6, OR=7.
  - Flag bit indices: FLAG_C=0, FLAG_Z=1, FLAG_V=2, FLAG_N=3.
  - FLAG_W=4.
- One sub-module, alu_result_fifo: generic width-parameterised FWFT storage holding pointers and count. The top level adds flag formation and statistics.

Test Plan:
- Reset, then push {result=6, command=ADD, all flags 0}, out_ready=0 -> next cycle out_valid=1, out_result=6, out_flags=4'b0000; held until out_ready=1, then out_valid=0.
- Push 5 entries back-to-back with out_ready=0, DEPTH=4 -> in_ready=0 after the 4th push; the 5th is not stored; draining yields exactly the first 4 in order.
- Steady stream with in_valid=1 and out_ready=1 at count=2 for 10 cycles -> count stays 2, output order matches input order, no drops.
- Push command=ADD, result=32'h8000_0000, overflow=1, carryout=1 -> out_flags=4'b1101, sticky_overflow=1, overflow_count=1. Push command=XOR with overflow=1 -> overflow_count stays 1.
- Force overflow_count=254, then 3 counted overflows -> 255 (saturated). clear_stats asserted together with a counted overflow -> overflow_count=0, sticky_overflow=0.
- With ALU_ZERO_RECOMPUTE_EN defined: push result=0, zero=0 -> out_flags[1]=1. Assert reset_n=0 while count=3 -> out_valid=0 immediately and count=0.
